// File: rtl/scmi_doorbell_scheduler_pkg.sv
// Shared types and defaults for the SCMI doorbell scheduler.
package scmi_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SERVE = 2'd2,
    COMPL = 2'd3
  } sched_state_e;

  localparam int DEF_NUM_CHANNELS   = 4;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  // Bit width needed to encode v distinct values, never less than one bit.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/scmi_doorbell_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer.
module scmi_rr_pick #(
  parameter int NumChannels = 4,
  parameter int IdWidth     = 2
) (
  input  logic [NumChannels-1:0] req_i,
  input  logic [IdWidth-1:0]     ptr_i,
  output logic                   valid_o,
  output logic [IdWidth-1:0]     idx_o
);

  // Rotate so bit 0 is the request sitting at the pointer.
  logic [NumChannels-1:0] w_rot;
  assign w_rot = NumChannels'({req_i, req_i} >> ptr_i);

  // Scan from the far end down so the nearest request to the pointer wins.
  always_comb begin
    int v_sum;
    v_sum   = 0;
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = NumChannels - 1; k >= 0; k--) begin
      if (((w_rot >> k) & NumChannels'(1)) != '0) begin
        v_sum = int'(ptr_i) + k;
        if (v_sum >= NumChannels) v_sum = v_sum - NumChannels;
        valid_o = 1'b1;
        idx_o   = IdWidth'(v_sum);
      end
    end
  end

endmodule

// File: rtl/scmi_doorbell_scheduler.sv
// SCMI doorbell scheduler: captures doorbell edges, picks channels round-robin,
// and walks each request through grant / serve / completion with a watchdog.
//
//  state | meaning
//  IDLE  | waiting for an enabled pending channel
//  GRANT | irq raised for r_id, waiting for firmware ack
//  SERVE | firmware working on r_id, waiting for done
//  COMPL | completion pulse on compl_o[r_id]
module scmi_doorbell_scheduler
  import scmi_sched_pkg::*;
#(
  parameter int  NumChannels   = DEF_NUM_CHANNELS,
  parameter int  TimeoutCycles = DEF_TIMEOUT_CYCLES,
  localparam int IdWidth       = clog2_min1(NumChannels)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumChannels-1:0] doorbell_i,
  input  logic [NumChannels-1:0] chan_en_i,
  output logic                   irq_o,
  output logic [IdWidth-1:0]     chan_id_o,
  input  logic                   ack_i,
  input  logic                   done_i,
  output logic [NumChannels-1:0] compl_o,
  output logic                   timeout_o,
  output logic                   busy_o
);

  localparam int                 CntWidth = clog2_min1(TimeoutCycles + 1);
  localparam logic [CntWidth-1:0] CntTerm = CntWidth'(TimeoutCycles - 1);
  localparam bit                 WdEnable = (TimeoutCycles != 0);
  localparam logic [IdWidth-1:0] LastIdx  = IdWidth'(NumChannels - 1);

  sched_state_e           r_state;
  logic [NumChannels-1:0] r_db_q;
  logic [NumChannels-1:0] r_pend;
  logic [IdWidth-1:0]     r_ptr;
  logic [IdWidth-1:0]     r_id;
  logic                   r_irq;
  logic [NumChannels-1:0] r_compl;
  logic                   r_timeout;
  logic [CntWidth-1:0]    r_wd_cnt;

  logic [NumChannels-1:0] w_cand;
  logic                   w_valid;
  logic [IdWidth-1:0]     w_idx;
  logic                   w_grant;
  logic [NumChannels-1:0] w_grant_mask;
  logic                   w_wd_exp;

  assign w_cand       = r_pend & chan_en_i;
  assign w_grant      = (r_state == IDLE) && w_valid;
  assign w_grant_mask = w_grant ? (NumChannels'(1) << w_idx) : '0;
  assign w_wd_exp     = WdEnable && (r_wd_cnt == CntTerm);

  scmi_rr_pick #(
    .NumChannels (NumChannels),
    .IdWidth     (IdWidth)
  ) u_rr_pick (
    .req_i   (w_cand),
    .ptr_i   (r_ptr),
    .valid_o (w_valid),
    .idx_o   (w_idx)
  );

  // Doorbell edge capture; a grant clears its bit even if the same channel rings again.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_db_q <= '0;
      r_pend <= '0;
    end else begin
      r_db_q <= doorbell_i;
      r_pend <= (r_pend | (doorbell_i & ~r_db_q)) & ~w_grant_mask;
    end
  end

  // Service FSM with registered irq / completion / timeout outputs and watchdog.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_id      <= '0;
      r_irq     <= 1'b0;
      r_compl   <= '0;
      r_timeout <= 1'b0;
      r_wd_cnt  <= '0;
    end else begin
      r_compl   <= '0;
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_id     <= w_idx;
            r_ptr    <= (w_idx == LastIdx) ? '0 : w_idx + IdWidth'(1);
            r_irq    <= 1'b1;
            r_wd_cnt <= '0;
            r_state  <= GRANT;
          end
        end
        GRANT: begin
          r_wd_cnt <= r_wd_cnt + CntWidth'(1);
          if (w_wd_exp) begin
            r_irq     <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= IDLE;
          end else if (ack_i) begin
            r_irq   <= 1'b0;
            r_state <= SERVE;
          end
        end
        SERVE: begin
          r_wd_cnt <= r_wd_cnt + CntWidth'(1);
          if (done_i) begin
            r_compl <= NumChannels'(1) << r_id;
            r_state <= COMPL;
          end else if (w_wd_exp) begin
            r_timeout <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign irq_o     = r_irq;
  assign chan_id_o = r_id;
  assign compl_o   = r_compl;
  assign timeout_o = r_timeout;
  assign busy_o    = (r_state != IDLE);

endmodule
